// File: rtl/fifo_stream_reader_if.sv
// Read-port and stream-side signals of fifo_stream_reader, grouped for port binding.
interface fifo_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  fifo_empty_i;
    logic                  fifo_rd_o;
    logic [DATA_WIDTH-1:0] fifo_q_i;
    logic                  flush_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  last_o;
    logic [CNT_WIDTH-1:0]  burst_cnt_o;

    // Reader side: consumes the FIFO read port, produces the stream.
    modport slave (
        input  fifo_empty_i,
        input  fifo_q_i,
        input  flush_i,
        input  ready_i,
        output fifo_rd_o,
        output data_o,
        output valid_o,
        output last_o,
        output burst_cnt_o
    );

    // Environment side: FIFO plus downstream consumer.
    modport master (
        output fifo_empty_i,
        output fifo_q_i,
        output flush_i,
        output ready_i,
        input  fifo_rd_o,
        input  data_o,
        input  valid_o,
        input  last_o,
        input  burst_cnt_o
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Turns a 1-cycle-latency FIFO read port into a full-throughput valid/ready
// stream using a 2-entry skid buffer, and tags burst boundaries with last_o.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fifo_stream_reader_if.slave  bus
);
    localparam int unsigned        LAST_IDX = (BURST_LEN == 0) ? 0 : BURST_LEN - 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(LAST_IDX);
    localparam logic               LAST_EN  = (BURST_LEN != 0);

    // Skid buffer: head_q is the oldest word, tail_q the second one.
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;

    logic                  pop_c;
    logic                  rd_c;
    logic [1:0]            after_pop_c;
    logic [2:0]            pending_c;

    // Read issue: occupancy after this cycle's pop plus the word in flight must leave a free slot.
    always_comb begin
        pop_c       = (count_q != 2'd0) && bus.ready_i;
        after_pop_c = count_q - 2'(pop_c);
        pending_c   = 3'(after_pop_c) + 3'(inflight_q);
        rd_c        = !bus.fifo_empty_i && !rst_i && !bus.flush_i && (pending_c < 3'd2);
    end

    // Next state: pop shifts the buffer, then the returning read word lands in the first free slot.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = pending_c[1:0];
        inflight_d  = rd_c;
        burst_cnt_d = burst_cnt_q;

        if (pop_c) begin
            head_d = tail_q;
            if (LAST_EN && (burst_cnt_q == LAST_CNT)) begin
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
            end
        end

        if (inflight_q) begin
            if (after_pop_c == 2'd0) begin
                head_d = bus.fifo_q_i;
            end else begin
                tail_d = bus.fifo_q_i;
            end
        end

        // Flush discards everything held or returning; a coinciding pop is not counted.
        if (bus.flush_i) begin
            count_d     = 2'd0;
            inflight_d  = 1'b0;
            burst_cnt_d = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // A returning word must always find a free slot.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !bus.flush_i && inflight_q) begin
            assert (after_pop_c != 2'd2);
        end
    end

    // Stream outputs decode directly from registered state.
    assign bus.fifo_rd_o   = rd_c;
    assign bus.data_o      = head_q;
    assign bus.valid_o     = (count_q != 2'd0);
    assign bus.last_o      = LAST_EN && (count_q != 2'd0) && (burst_cnt_q == LAST_CNT);
    assign bus.burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: one DUT with BURST_LEN=64, one with BURST_LEN=4.
module tb_fifo_stream_reader;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fifo_stream_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus_a ();
    fifo_stream_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus_b ();

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(64), .CNT_WIDTH(CW)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(4), .CNT_WIDTH(CW)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models with 1-cycle read latency.
    logic [DW-1:0] mem_a [0:63];
    logic [DW-1:0] mem_b [0:63];
    int wptr_a = 0, rptr_a = 0, wptr_b = 0, rptr_b = 0;

    assign bus_a.fifo_empty_i = (wptr_a == rptr_a);
    assign bus_b.fifo_empty_i = (wptr_b == rptr_b);

    always @(posedge clk) begin
        if (bus_a.fifo_rd_o) begin
            bus_a.fifo_q_i <= mem_a[rptr_a % 64];
            rptr_a         <= rptr_a + 1;
        end
        if (bus_b.fifo_rd_o) begin
            bus_b.fifo_q_i <= mem_b[rptr_b % 64];
            rptr_b         <= rptr_b + 1;
        end
    end

    task automatic push_a(input logic [DW-1:0] w);
        mem_a[wptr_a % 64] = w;
        wptr_a++;
    endtask

    task automatic push_b(input logic [DW-1:0] w);
        mem_b[wptr_b % 64] = w;
        wptr_b++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus_a.valid_o !== 1'b0 || bus_a.data_o !== 16'h0 || bus_a.last_o !== 1'b0 ||
                bus_a.burst_cnt_o !== 16'h0 || bus_a.fifo_rd_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_a k=%0d got v=%b d=%h l=%b c=%0d rd=%b exp all zero", k,
                         bus_a.valid_o, bus_a.data_o, bus_a.last_o, bus_a.burst_cnt_o, bus_a.fifo_rd_o);
            end
            checks++;
            if (bus_b.valid_o !== 1'b0 || bus_b.data_o !== 16'h0 || bus_b.last_o !== 1'b0 ||
                bus_b.burst_cnt_o !== 16'h0 || bus_b.fifo_rd_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_b k=%0d got v=%b d=%h l=%b c=%0d rd=%b exp all zero", k,
                         bus_b.valid_o, bus_b.data_o, bus_b.last_o, bus_b.burst_cnt_o, bus_b.fifo_rd_o);
            end
            rst = 1'b0;
            tick();
        end
    endtask

    // 8 words, sink always ready: reads C0..C7, valid C2..C9 with no gaps.
    task automatic test_stream();
        logic          rd_e, v_e;
        logic [DW-1:0] d_e, c_e;
        bus_a.ready_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 0) for (int i = 1; i <= 8; i++) push_a(16'(i));
            #1;
            rd_e = (c < 8);
            v_e  = (c >= 2) && (c < 10);
            d_e  = 16'(c - 1);
            c_e  = (c < 2) ? 16'd0 : (c < 10) ? 16'(c - 2) : 16'd8;
            checks++;
            if (bus_a.fifo_rd_o !== rd_e) begin
                errors++; $display("FAIL stream_rd c=%0d got %b exp %b", c, bus_a.fifo_rd_o, rd_e);
            end
            checks++;
            if (bus_a.valid_o !== v_e) begin
                errors++; $display("FAIL stream_valid c=%0d got %b exp %b", c, bus_a.valid_o, v_e);
            end
            if (v_e) begin
                checks++;
                if (bus_a.data_o !== d_e) begin
                    errors++; $display("FAIL stream_data c=%0d got %h exp %h", c, bus_a.data_o, d_e);
                end
            end
            checks++;
            if (bus_a.burst_cnt_o !== c_e || bus_a.last_o !== 1'b0) begin
                errors++;
                $display("FAIL stream_cnt c=%0d got cnt=%0d last=%b exp cnt=%0d last=0", c,
                         bus_a.burst_cnt_o, bus_a.last_o, c_e);
            end
        end
    endtask

    // BURST_LEN=4, 10 words: last_o only on 0x0013 and 0x0017.
    task automatic test_burst();
        logic [DW-1:0] cnt_tab [0:9];
        logic          v_e, l_e;
        logic [DW-1:0] d_e, c_e;
        cnt_tab = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
        bus_b.ready_i = 1'b1;
        for (int c = 0; c < 13; c++) begin
            tick();
            if (c == 0) for (int i = 0; i < 10; i++) push_b(16'(16'h0010 + i));
            #1;
            v_e = (c >= 2) && (c < 12);
            d_e = 16'(16'h0010 + c - 2);
            c_e = (c < 2) ? 16'd0 : (c < 12) ? cnt_tab[c - 2] : 16'd2;
            l_e = v_e && ((d_e == 16'h0013) || (d_e == 16'h0017));
            checks++;
            if (bus_b.valid_o !== v_e) begin
                errors++; $display("FAIL burst_valid c=%0d got %b exp %b", c, bus_b.valid_o, v_e);
            end
            if (v_e) begin
                checks++;
                if (bus_b.data_o !== d_e) begin
                    errors++; $display("FAIL burst_data c=%0d got %h exp %h", c, bus_b.data_o, d_e);
                end
            end
            checks++;
            if (bus_b.burst_cnt_o !== c_e) begin
                errors++; $display("FAIL burst_cnt c=%0d got %0d exp %0d", c, bus_b.burst_cnt_o, c_e);
            end
            checks++;
            if (bus_b.last_o !== l_e) begin
                errors++; $display("FAIL burst_last c=%0d got %b exp %b", c, bus_b.last_o, l_e);
            end
        end
        bus_b.ready_i = 1'b0;
    endtask

    // 6 words with ready toggling: reads throttle at 2 outstanding, outputs hold while stalled.
    task automatic test_stall();
        logic [15:0]   ready_pat, rd_pat;
        logic [DW-1:0] got [0:7];
        int            n;
        logic          prev_stall;
        logic [DW-1:0] prev_data, prev_cnt;
        ready_pat  = 16'hAAA9;
        rd_pat     = 16'h02AB;
        n          = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_cnt   = '0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (c == 0) for (int i = 0; i < 6; i++) push_a(16'(16'h0020 + i));
            bus_a.ready_i = ready_pat[c];
            #1;
            checks++;
            if (bus_a.fifo_rd_o !== rd_pat[c]) begin
                errors++; $display("FAIL stall_rd c=%0d got %b exp %b", c, bus_a.fifo_rd_o, rd_pat[c]);
            end
            checks++;
            if (bus_a.fifo_rd_o === 1'b1 && bus_a.fifo_empty_i === 1'b1) begin
                errors++; $display("FAIL stall_rd_empty c=%0d got rd=1 with empty=1 exp rd=0", c);
            end
            if (prev_stall) begin
                checks++;
                if (bus_a.valid_o !== 1'b1 || bus_a.data_o !== prev_data || bus_a.burst_cnt_o !== prev_cnt) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d got v=%b d=%h cnt=%0d exp v=1 d=%h cnt=%0d", c,
                             bus_a.valid_o, bus_a.data_o, bus_a.burst_cnt_o, prev_data, prev_cnt);
                end
            end
            if (bus_a.valid_o === 1'b1 && bus_a.ready_i === 1'b1) begin
                if (n < 8) got[n] = bus_a.data_o;
                n++;
            end
            prev_stall = (bus_a.valid_o === 1'b1) && !bus_a.ready_i;
            prev_data  = bus_a.data_o;
            prev_cnt   = bus_a.burst_cnt_o;
        end
        checks++;
        if (n != 6) begin
            errors++; $display("FAIL stall_count got %0d exp 6", n);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== 16'(16'h0020 + i)) begin
                errors++; $display("FAIL stall_order i=%0d got %h exp %h", i, got[i], 16'(16'h0020 + i));
            end
        end
        checks++;
        if (bus_a.burst_cnt_o !== 16'd14) begin
            errors++; $display("FAIL stall_final_cnt got %0d exp 14", bus_a.burst_cnt_o);
        end
    endtask

    // FIFO drains after 3 words, 0x00A0 arrives 3 cycles later; counter continues at 3.
    task automatic test_refill();
        logic          rd_e, v_e;
        logic [DW-1:0] d_e, c_e;
        pulse_reset();
        bus_a.ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) for (int i = 0; i < 3; i++) push_a(16'(16'h0030 + i));
            if (c == 6) push_a(16'h00A0);
            #1;
            rd_e = (c <= 2) || (c == 6);
            v_e  = ((c >= 2) && (c <= 4)) || (c == 8);
            d_e  = (c == 8) ? 16'h00A0 : 16'(16'h0030 + c - 2);
            c_e  = (c < 2) ? 16'd0 : (c <= 4) ? 16'(c - 2) : (c <= 8) ? 16'd3 : 16'd4;
            checks++;
            if (bus_a.fifo_rd_o !== rd_e) begin
                errors++; $display("FAIL refill_rd c=%0d got %b exp %b", c, bus_a.fifo_rd_o, rd_e);
            end
            checks++;
            if (bus_a.valid_o !== v_e) begin
                errors++; $display("FAIL refill_valid c=%0d got %b exp %b", c, bus_a.valid_o, v_e);
            end
            if (v_e) begin
                checks++;
                if (bus_a.data_o !== d_e) begin
                    errors++; $display("FAIL refill_data c=%0d got %h exp %h", c, bus_a.data_o, d_e);
                end
            end
            checks++;
            if (bus_a.burst_cnt_o !== c_e) begin
                errors++; $display("FAIL refill_cnt c=%0d got %0d exp %0d", c, bus_a.burst_cnt_o, c_e);
            end
        end
    endtask

    // Flush at C7 with one word buffered and one in flight (0x0046), coinciding with a pop.
    task automatic test_flush();
        logic          rd_e, v_e;
        logic [DW-1:0] d_e, c_e;
        pulse_reset();
        bus_a.ready_i = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (c == 0) for (int i = 0; i < 10; i++) push_a(16'(16'h0040 + i));
            bus_a.flush_i = (c == 7);
            #1;
            rd_e = (c <= 6) || ((c >= 8) && (c <= 10));
            v_e  = ((c >= 2) && (c <= 7)) || ((c >= 10) && (c <= 12));
            d_e  = (c <= 7) ? 16'(16'h0040 + c - 2) : 16'(16'h0047 + c - 10);
            c_e  = (c < 2) ? 16'd0 : (c <= 7) ? 16'(c - 2) : (c <= 9) ? 16'd0 :
                   (c <= 12) ? 16'(c - 10) : 16'd3;
            checks++;
            if (bus_a.fifo_rd_o !== rd_e) begin
                errors++; $display("FAIL flush_rd c=%0d got %b exp %b", c, bus_a.fifo_rd_o, rd_e);
            end
            checks++;
            if (bus_a.valid_o !== v_e) begin
                errors++; $display("FAIL flush_valid c=%0d got %b exp %b", c, bus_a.valid_o, v_e);
            end
            if (v_e) begin
                checks++;
                if (bus_a.data_o !== d_e) begin
                    errors++; $display("FAIL flush_data c=%0d got %h exp %h", c, bus_a.data_o, d_e);
                end
            end
            checks++;
            if (bus_a.burst_cnt_o !== c_e) begin
                errors++; $display("FAIL flush_cnt c=%0d got %0d exp %0d", c, bus_a.burst_cnt_o, c_e);
            end
        end
        bus_a.flush_i = 1'b0;
    endtask

    // One-cycle reset at C4 while stalled, then clean restart from the next FIFO word.
    task automatic test_midreset();
        logic          rd_e, v_e;
        logic [DW-1:0] d_e, c_e;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 0) for (int i = 0; i < 8; i++) push_a(16'(16'h0050 + i));
            bus_a.ready_i = (c != 4);
            rst           = (c == 4);
            #1;
            rd_e = (c <= 3) || ((c >= 5) && (c <= 8));
            v_e  = ((c >= 2) && (c <= 4)) || ((c >= 7) && (c <= 10));
            d_e  = (c <= 4) ? 16'(16'h0050 + c - 2) : (c <= 6) ? 16'h0000 : 16'(16'h0054 + c - 7);
            c_e  = (c <= 2) ? 16'd3 : (c == 3) ? 16'd4 : (c == 4) ? 16'd5 : (c <= 6) ? 16'd0 :
                   (c <= 10) ? 16'(c - 7) : 16'd4;
            checks++;
            if (bus_a.fifo_rd_o !== rd_e) begin
                errors++; $display("FAIL mrst_rd c=%0d got %b exp %b", c, bus_a.fifo_rd_o, rd_e);
            end
            checks++;
            if (bus_a.valid_o !== v_e) begin
                errors++; $display("FAIL mrst_valid c=%0d got %b exp %b", c, bus_a.valid_o, v_e);
            end
            if (v_e || c == 5) begin
                checks++;
                if (bus_a.data_o !== d_e) begin
                    errors++; $display("FAIL mrst_data c=%0d got %h exp %h", c, bus_a.data_o, d_e);
                end
            end
            checks++;
            if (bus_a.burst_cnt_o !== c_e || bus_a.last_o !== 1'b0) begin
                errors++;
                $display("FAIL mrst_cnt c=%0d got cnt=%0d last=%b exp cnt=%0d last=0", c,
                         bus_a.burst_cnt_o, bus_a.last_o, c_e);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus_a.ready_i = 1'b0;
        bus_a.flush_i = 1'b0;
        bus_b.ready_i = 1'b0;
        bus_b.flush_i = 1'b0;
        test_reset();
        test_stream();
        test_burst();
        test_stall();
        test_refill();
        test_flush();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
